// File: rtl/tempsens_avg_if.sv
// ---------------------------------------------------------------------------
// tempsens_if
// Bundle of signals between the tempsense measurement controller (master)
// and the moving-average / min-max filter (slave).
//   i_sample_valid  master->slave  1-cycle strobe, new raw result on i_sample
//   i_sample        master->slave  raw result, W bits
//   i_clear         master->slave  synchronous restart of window and min/max
//   o_avg           slave->master  rounded window average
//   o_avg_upd       slave->master  1-cycle pulse when o_avg is refreshed
//   o_avg_valid     slave->master  window has been filled at least once
//   o_min / o_max   slave->master  extreme samples since reset/clear
//   o_mm_valid      slave->master  at least one sample accepted
// ---------------------------------------------------------------------------
interface tempsens_if #(
    parameter int W = 7
);
    logic         i_sample_valid;
    logic [W-1:0] i_sample;
    logic         i_clear;
    logic [W-1:0] o_avg;
    logic         o_avg_upd;
    logic         o_avg_valid;
    logic [W-1:0] o_min;
    logic [W-1:0] o_max;
    logic         o_mm_valid;

    modport master (
        output i_sample_valid, i_sample, i_clear,
        input  o_avg, o_avg_upd, o_avg_valid, o_min, o_max, o_mm_valid
    );

    modport slave (
        input  i_sample_valid, i_sample, i_clear,
        output o_avg, o_avg_upd, o_avg_valid, o_min, o_max, o_mm_valid
    );
endinterface

// File: rtl/tempsens_avg.sv
// ---------------------------------------------------------------------------
// tempsens_avg
// Moving-average and min/max filter on the raw temperature-sensor result.
// Keeps a circular window of the last DEPTH = 2**LOG2_DEPTH samples with a
// running sum; once the window is full every accepted sample refreshes the
// rounded average one cycle later. Min/max track all samples since the last
// reset or clear.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    tempsens_if.slave (sample strobe/data/clear in, avg/min/max out)
// ---------------------------------------------------------------------------
module tempsens_avg #(
    parameter int W          = 7,
    parameter int LOG2_DEPTH = 3
) (
    input  logic      clk,
    input  logic      reset,
    tempsens_if.slave bus
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int SUM_W = W + LOG2_DEPTH;

    localparam logic [LOG2_DEPTH-1:0] CNT_LAST = LOG2_DEPTH'(DEPTH - 1);
    localparam logic [LOG2_DEPTH-1:0] CNT_ONE  = LOG2_DEPTH'(1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Round half up: add half an LSB of the quotient before dividing by DEPTH.
    // The largest possible sum plus the bias still fits SUM_W bits.
    function automatic logic [W-1:0] round_avg(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] t;
        t = (s + SUM_W'(DEPTH / 2)) >> LOG2_DEPTH;
        return W'(t);
    endfunction

    state_t                state, state_nxt;
    logic [LOG2_DEPTH-1:0] fill_cnt, fill_cnt_nxt;
    logic                  upd_nxt;

    logic [W-1:0]          sample_buf [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [SUM_W-1:0]      sum_p0;
    logic                  vld_p0;

    logic [W-1:0]          avg_p1;
    logic                  vld_p1;
    logic                  avg_valid;

    logic [W-1:0]          min_r;
    logic [W-1:0]          max_r;
    logic                  mm_valid;

    logic                  restart;
    logic                  accept;

    // Clear behaves exactly like reset and beats a simultaneous strobe.
    assign restart = reset || bus.i_clear;
    assign accept  = bus.i_sample_valid && !bus.i_clear;

    always_ff @(posedge clk) begin
        if (restart) begin
            state    <= FILL;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
        end
    end

    // Every accept that leaves the block in RUN (including the one that
    // completes the fill) schedules an average refresh.
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        upd_nxt      = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (fill_cnt == CNT_LAST) begin
                        state_nxt = RUN;
                        upd_nxt   = 1'b1;
                    end else begin
                        fill_cnt_nxt = fill_cnt + CNT_ONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    upd_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // ---- stage 0: window write, running sum, min/max ----
    always_ff @(posedge clk) begin
        if (restart) begin
            for (int i = 0; i < DEPTH; i++) begin
                sample_buf[i] <= '0;
            end
            wr_ptr   <= '0;
            sum_p0   <= '0;
            vld_p0   <= 1'b0;
            min_r    <= '1;
            max_r    <= '0;
            mm_valid <= 1'b0;
        end else begin
            vld_p0 <= upd_nxt;
            if (accept) begin
                sample_buf[wr_ptr] <= bus.i_sample;
                // The outgoing sample is part of sum_p0, so this never underflows.
                sum_p0 <= sum_p0 + SUM_W'(bus.i_sample) - SUM_W'(sample_buf[wr_ptr]);
                wr_ptr <= wr_ptr + CNT_ONE;
                if (!mm_valid) begin
                    min_r <= bus.i_sample;
                    max_r <= bus.i_sample;
                end else begin
                    if (bus.i_sample < min_r) min_r <= bus.i_sample;
                    if (bus.i_sample > max_r) max_r <= bus.i_sample;
                end
                mm_valid <= 1'b1;
            end
        end
    end

    // ---- stage 1: rounded average register ----
    always_ff @(posedge clk) begin
        if (restart) begin
            avg_p1    <= '0;
            vld_p1    <= 1'b0;
            avg_valid <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                avg_p1    <= round_avg(sum_p0);
                avg_valid <= 1'b1;
            end
        end
    end

    assign bus.o_avg       = avg_p1;
    assign bus.o_avg_upd   = vld_p1;
    assign bus.o_avg_valid = avg_valid;
    assign bus.o_min       = min_r;
    assign bus.o_max       = max_r;
    assign bus.o_mm_valid  = mm_valid;

endmodule
